// File: rtl/lcd_write_sequencer.sv
// Write-only HD44780 8-bit sequencer: setup / enable / hold / exec timing per byte.
// Define LCD_POWERUP_INIT_EN to run the power-up wait and 6-entry init ROM after reset.
`timescale 1ns/1ps

module lcd_write_sequencer #(
    parameter int unsigned T_SETUP_CYC = 2,
    parameter int unsigned T_EN_CYC    = 12,
    parameter int unsigned T_HOLD_CYC  = 2,
    parameter int unsigned T_EXEC_CYC  = 2000,
    parameter int unsigned T_LONG_CYC  = 82000,
    parameter int unsigned T_PWRUP_CYC = 750000
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rs,
    input  logic [7:0]  cmd_data,
    output logic        busy,
    output logic        init_done,
    output logic [10:0] lcd_wire_export
);

    // state      | meaning
    // PWRUP      | post-reset wait before the first init write
    // INIT_LOAD  | latch init ROM entry idx as an instruction
    // SETUP      | RS/DATA driven, EN low
    // PULSE      | EN high
    // HOLD       | EN low, RS/DATA unchanged
    // EXEC       | LCD execution delay (long for clear/home)
    // IDLE       | ready for the next byte, bus holds last write

    localparam int unsigned MAX_A   = (T_SETUP_CYC > T_EN_CYC) ? T_SETUP_CYC : T_EN_CYC;
    localparam int unsigned MAX_B   = (T_HOLD_CYC > T_EXEC_CYC) ? T_HOLD_CYC : T_EXEC_CYC;
    localparam int unsigned MAX_C   = (T_LONG_CYC > T_PWRUP_CYC) ? T_LONG_CYC : T_PWRUP_CYC;
    localparam int unsigned MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned MAX_CYC = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
    localparam int          CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN_CYC - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC_CYC - 1);
    localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_LONG_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef LCD_POWERUP_INIT_EN
    localparam logic [2:0] S_PWRUP     = 3'd0;
    localparam logic [2:0] S_INIT_LOAD = 3'd1;
    localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(T_PWRUP_CYC - 1);
`endif
    localparam logic [2:0] S_SETUP = 3'd2;
    localparam logic [2:0] S_PULSE = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_EXEC  = 3'd5;
    localparam logic [2:0] S_IDLE  = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic             cnt_zero;
    logic             long_wait;

`ifdef LCD_POWERUP_INIT_EN
    logic [2:0] idx_q, idx_d;
    logic       init_done_q, init_done_d;

    function automatic logic [7:0] init_rom(input logic [2:0] i);
        case (i)
            3'd0, 3'd1, 3'd2: init_rom = 8'h38;
            3'd3:             init_rom = 8'h0C;
            3'd4:             init_rom = 8'h01;
            default:          init_rom = 8'h06;
        endcase
    endfunction
`endif

    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        long_wait = !rs_q && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03);
`ifdef LCD_POWERUP_INIT_EN
        // the first function-set after power-up needs the long settle time
        if (!init_done_q && idx_q == 3'd0) long_wait = 1'b1;
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_zero ? cnt_q : cnt_q - CNT_ONE;
        rs_d    = rs_q;
        data_d  = data_q;
`ifdef LCD_POWERUP_INIT_EN
        idx_d       = idx_q;
        init_done_d = init_done_q;
`endif
        case (state_q)
`ifdef LCD_POWERUP_INIT_EN
            S_PWRUP: if (cnt_zero) state_d = S_INIT_LOAD;
            S_INIT_LOAD: begin
                rs_d    = 1'b0;
                data_d  = init_rom(idx_q);
                cnt_d   = LD_SETUP;
                state_d = S_SETUP;
            end
`endif
            S_IDLE: begin
                if (cmd_valid) begin
                    rs_d    = cmd_rs;
                    data_d  = cmd_data;
                    cnt_d   = LD_SETUP;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: if (cnt_zero) begin
                cnt_d   = LD_EN;
                state_d = S_PULSE;
            end
            S_PULSE: if (cnt_zero) begin
                cnt_d   = LD_HOLD;
                state_d = S_HOLD;
            end
            S_HOLD: if (cnt_zero) begin
                cnt_d   = long_wait ? LD_LONG : LD_EXEC;
                state_d = S_EXEC;
            end
            S_EXEC: if (cnt_zero) begin
                state_d = S_IDLE;
`ifdef LCD_POWERUP_INIT_EN
                if (!init_done_q) begin
                    if (idx_q == 3'd5) begin
                        init_done_d = 1'b1;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_INIT_LOAD;
                    end
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
`ifdef LCD_POWERUP_INIT_EN
            state_q     <= S_PWRUP;
            cnt_q       <= LD_PWRUP;
            idx_q       <= 3'd0;
            init_done_q <= 1'b0;
`else
            state_q     <= S_IDLE;
            cnt_q       <= '0;
`endif
            rs_q        <= 1'b0;
            data_q      <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rs_q        <= rs_d;
            data_q      <= data_d;
`ifdef LCD_POWERUP_INIT_EN
            idx_q       <= idx_d;
            init_done_q <= init_done_d;
`endif
        end
    end

`ifdef LCD_POWERUP_INIT_EN
    assign init_done = init_done_q;
`else
    assign init_done = 1'b1;
`endif
    assign cmd_ready       = (state_q == S_IDLE);
    assign busy            = !cmd_ready;
    assign lcd_wire_export = {state_q == S_PULSE, 1'b0, rs_q, data_q};

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Directed bench for lcd_write_sequencer with shortened timing parameters.
// Covers both builds; the init-sequence checks apply when LCD_POWERUP_INIT_EN is defined.
`timescale 1ns/1ps

module tb_lcd_write_sequencer;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rs;
    logic [7:0]  cmd_data;
    logic        busy;
    logic        init_done;
    logic [10:0] bus;

    int checks = 0;
    int errors = 0;

    lcd_write_sequencer #(
        .T_SETUP_CYC(2), .T_EN_CYC(4), .T_HOLD_CYC(2),
        .T_EXEC_CYC(10), .T_LONG_CYC(50), .T_PWRUP_CYC(100)
    ) dut (
        .clk_clk(clk), .reset_reset(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rs(cmd_rs), .cmd_data(cmd_data), .busy(busy), .init_done(init_done),
        .lcd_wire_export(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         rdy_j;   // sample index (DATA first visible = 1) where cmd_ready returns
    } vec_t;

    vec_t vecs[8];
    logic [7:0] exp_rom[6];
    int exp_gap[5];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        for (int i = 0; i < 600; i++) begin
            if (cmd_ready) break;
            @(negedge clk);
        end
        check({name, "_ready"}, int'(cmd_ready), 1);
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_bus", int'(bus), 0);
`ifdef LCD_POWERUP_INIT_EN
        check("rst_ready", int'(cmd_ready), 0);
        check("rst_busy", int'(busy), 1);
        check("rst_init_done", int'(init_done), 0);
`endif
        rst = 1'b0;
    endtask

`ifdef LCD_POWERUP_INIT_EN
    // Sampling starts on the negedge right after the last reset edge (j=1).
    // Zero-EN gap between pulses = HOLD + EXEC + INIT_LOAD + SETUP.
    task automatic powerup_check(input string name);
        int first_rise = -1, pulses = 0, zeros = 0, last_end = -1, rdy_j = -1;
        int sync_err = 0, rs_err = 0;
        int plen[6];
        int gap[5];
        logic [7:0] pdata[6];
        logic prev_en = 1'b0;
        for (int k = 0; k < 6; k++) begin plen[k] = 0; pdata[k] = 8'h00; end
        for (int k = 0; k < 5; k++) gap[k] = 0;
        for (int j = 1; j <= 400; j++) begin
            if (cmd_ready != init_done) sync_err++;
            if (bus[10] && !prev_en) begin
                if (pulses == 0) first_rise = j;
                else if (pulses < 6) gap[pulses-1] = zeros;
                if (pulses < 6) begin
                    pdata[pulses] = bus[7:0];
                    if (bus[8]) rs_err++;
                end
                pulses++;
                zeros = 0;
            end
            if (bus[10]) begin
                if (pulses <= 6) plen[pulses-1]++;
                last_end = j;
            end else begin
                zeros++;
            end
            prev_en = bus[10];
            if (cmd_ready) begin rdy_j = j; break; end
            @(negedge clk);
        end
        check({name, "_first_rise"}, first_rise, 104);
        check({name, "_pulses"}, pulses, 6);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("%s_data%0d", name, k), int'(pdata[k]), int'(exp_rom[k]));
            check($sformatf("%s_len%0d", name, k), plen[k], 4);
        end
        for (int k = 0; k < 5; k++)
            check($sformatf("%s_gap%0d", name, k), gap[k], exp_gap[k]);
        check({name, "_rdy_after_last"}, rdy_j - last_end, 13);
        check({name, "_ready_vs_init_done"}, sync_err, 0);
        check({name, "_rs_zero"}, rs_err, 0);
    endtask
`endif

    task automatic do_write(input logic rs, input logic [7:0] d, input int exp_rdy, input string name);
        int rdy_j = -1, en_first = -1, en_cnt = 0, unstable = 0;
        logic [8:0] expv;
        expv = {rs, d};
        wait_ready(name);
        cmd_valid = 1'b1;
        cmd_rs = rs;
        cmd_data = d;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_rs = ~rs;
        cmd_data = ~d;
        check({name, "_bus"}, int'(bus[8:0]), int'(expv));
        check({name, "_busy"}, int'(busy), 1);
        for (int j = 1; j <= 200; j++) begin
            if (bus[10]) begin
                if (en_first < 0) en_first = j;
                en_cnt++;
            end
            if (bus[8:0] != expv || bus[9]) unstable++;
            if (cmd_ready) begin rdy_j = j; break; end
            @(negedge clk);
        end
        check({name, "_en_first"}, en_first, 3);
        check({name, "_en_len"}, en_cnt, 4);
        check({name, "_rdy"}, rdy_j, exp_rdy);
        check({name, "_stable"}, unstable, 0);
        @(negedge clk);
        check({name, "_idle_hold"}, int'(bus), int'({2'b00, expv}));
    endtask

    task automatic back_to_back();
        int rises = 0;
        int rpos[2];
        logic [8:0] rval[2];
        logic prev_en = 1'b0;
        rpos[0] = -1; rpos[1] = -1; rval[0] = '0; rval[1] = '0;
        wait_ready("b2b");
        cmd_valid = 1'b1;
        cmd_rs = 1'b1;
        cmd_data = 8'h48;
        @(posedge clk);
        @(negedge clk);
        cmd_data = 8'h49;
        for (int j = 1; j <= 70; j++) begin
            if (bus[10] && !prev_en) begin
                if (rises < 2) begin rpos[rises] = j; rval[rises] = bus[8:0]; end
                rises++;
                if (rises == 2) cmd_valid = 1'b0;
            end
            prev_en = bus[10];
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check("b2b_pulses", rises, 2);
        check("b2b_first_rise", rpos[0], 3);
        check("b2b_spacing", rpos[1] - rpos[0], 19);
        check("b2b_byte0", int'(rval[0]), 9'h148);
        check("b2b_byte1", int'(rval[1]), 9'h149);
    endtask

    initial begin
        int en_seen;
        vecs[0] = '{rs: 1'b1, data: 8'h41, rdy_j: 19};
        vecs[1] = '{rs: 1'b0, data: 8'h01, rdy_j: 59};
        vecs[2] = '{rs: 1'b0, data: 8'h80, rdy_j: 19};
        vecs[3] = '{rs: 1'b0, data: 8'h02, rdy_j: 59};
        vecs[4] = '{rs: 1'b0, data: 8'h03, rdy_j: 59};
        vecs[5] = '{rs: 1'b0, data: 8'h04, rdy_j: 19};
        vecs[6] = '{rs: 1'b1, data: 8'h01, rdy_j: 19};
        vecs[7] = '{rs: 1'b0, data: 8'h00, rdy_j: 19};
        exp_rom[0] = 8'h38; exp_rom[1] = 8'h38; exp_rom[2] = 8'h38;
        exp_rom[3] = 8'h0C; exp_rom[4] = 8'h01; exp_rom[5] = 8'h06;
        exp_gap[0] = 55; exp_gap[1] = 15; exp_gap[2] = 15; exp_gap[3] = 15; exp_gap[4] = 55;

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_rs = 1'b0;
        cmd_data = 8'h00;
        @(negedge clk);
        do_reset();
`ifdef LCD_POWERUP_INIT_EN
        powerup_check("pwrup");
`else
        @(negedge clk);
        check("post_rst_ready", int'(cmd_ready), 1);
        check("post_rst_init_done", int'(init_done), 1);
        check("post_rst_busy", int'(busy), 0);
`endif

        for (int i = 0; i < 8; i++)
            do_write(vecs[i].rs, vecs[i].data, vecs[i].rdy_j, $sformatf("vec%0d", i));

        back_to_back();

        // reset while EN is high
        wait_ready("midpulse");
        cmd_valid = 1'b1;
        cmd_rs = 1'b1;
        cmd_data = 8'h55;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        en_seen = 0;
        for (int j = 0; j < 20; j++) begin
            if (bus[10]) begin en_seen = 1; break; end
            @(negedge clk);
        end
        check("midpulse_en_seen", en_seen, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midpulse_bus", int'(bus), 0);
`ifdef LCD_POWERUP_INIT_EN
        check("midpulse_busy", int'(busy), 1);
        check("midpulse_init_done", int'(init_done), 0);
        rst = 1'b0;
        powerup_check("restart");
`else
        rst = 1'b0;
        @(negedge clk);
        check("midpulse_ready", int'(cmd_ready), 1);
        check("midpulse_init_done", int'(init_done), 1);
`endif
        do_write(1'b1, 8'h30, 19, "after_rst");

        // reset and cmd_valid together: byte dropped
        wait_ready("simul");
        cmd_valid = 1'b1;
        cmd_rs = 1'b1;
        cmd_data = 8'h77;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        rst = 1'b0;
        check("simul_bus", int'(bus), 0);
`ifdef LCD_POWERUP_INIT_EN
        powerup_check("simul_pwrup");
`else
        en_seen = 0;
        for (int j = 0; j < 20; j++) begin
            if (bus[10]) en_seen++;
            @(negedge clk);
        end
        check("simul_no_pulse", en_seen, 0);
        check("simul_ready", int'(cmd_ready), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
